mem_wb_ldst: RTL and testbench
==============================

Name: mem_wb_ldst

Overview:
- Load/store access unit and MEM/WB pipeline register, directly downstream of the MEM stage.
- Consumes the MEM stage's address, write data, byte enables, read/write strobes and control word.
- Drives the data-cache handshake and stalls the pipe until the cache responds.
- Aligns and sign-extends load data, then registers everything WB needs.

Parameters:
width, 32, datapath/address width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_valid_i  in  1  MEM stage holds a live instruction
mem_read_i  in  1  load request
mem_write_i  in  1  store request
mem_addr_i  in  width  byte address (marmux output)
mem_wdata_i  in  width  unshifted rs2 store data
mem_byte_en_i  in  4  byte enables, already shifted by addr[1:0]
mem_ctrl_word_i  in  rv32i_control_word  control word (funct3, load_regfile, opcode)
mem_rd_i  in  5  destination register
mem_alu_out_i  in  width  ALU result
mem_pc_plus4_i  in  width  PC+4
mem_instr_i  in  width  instruction bits
flush_i  in  1  kill the current MEM instruction (branch redirect)
stall_o  out  1  freeze IF..MEM this cycle
dmem_read_o  out  1  cache read strobe
dmem_write_o  out  1  cache write strobe
dmem_address_o  out  width  word-aligned address
dmem_wdata_o  out  width  store data shifted into lane
dmem_mbe_o  out  4  byte mask
dmem_resp_i  in  1  cache done (one-cycle pulse)
dmem_rdata_i  in  width  cache read data, valid with resp
wb_valid_o  out  1  WB holds a live instruction
wb_ctrl_word_o  out  rv32i_control_word  registered control word
wb_rd_o  out  5  registered rd
wb_alu_out_o  out  width  registered ALU result
wb_load_data_o  out  width  registered aligned/extended load data
wb_pc_plus4_o  out  width  registered PC+4
wb_instr_o  out  width  registered instruction

Behaviour:
- FSM states: IDLE, BUSY.
- Define access = mem_valid_i & (mem_read_i | mem_write_i).
- IDLE, access, no flush_i:
  - stall_o=1.
  - At the edge, register dmem_address_o={addr[31:2],2'b00}, dmem_wdata_o=wdata<<(8*addr[1:0]), dmem_mbe_o=mem_byte_en_i.
  - Register dmem_write_o=mem_write_i and dmem_read_o=mem_read_i&~mem_write_i; read+write together means write wins and no load data is produced.
  - Go to BUSY.
- IDLE, no access: stall_o=0; the instruction passes to WB in 1 cycle.
- BUSY:
  - All dmem_* outputs hold stable.
  - stall_o = ~dmem_resp_i.
  - On dmem_resp_i: load data is extracted combinationally from dmem_rdata_i and captured into the WB register; dmem_read_o/dmem_write_o drop to 0 at that edge; go to IDLE.
- Memory op latency: minimum 2 cycles (issue + resp). A resp in the first BUSY cycle gives writeback on the following edge.
- WB register, every edge:
  - stall_o=1: load a bubble (wb_valid_o=0, wb_ctrl_word_o.load_regfile=0; other fields don't care).
  - Otherwise capture the inputs, with wb_valid_o = mem_valid_i & ~flush_i.
- Load extraction: s = dmem_rdata_i >> (8*addr[1:0]), where addr is the registered access address.
  - lb = sext(s[7:0]); lbu = zext(s[7:0]).
  - lh = sext(s[15:0]); lhu = zext(s[15:0]).
  - lw = s.
  - Other funct3 values give s.
- Misaligned access: no trap; bytes shifted out read as 0. Example: lh at offset 3 returns sext({8'h00, byte3}) = {16'h0, 8'h00, byte3}.
- Stores and non-loads: wb_load_data_o = 0.
- flush_i in IDLE with access: no request issued, no stall, WB gets a bubble.
- flush_i during BUSY: the request still completes (no abort); the result is written to WB as a bubble (sticky kill bit cleared on return to IDLE).
- Reset (synchronous, any state, including mid-BUSY):
  - state=IDLE.
  - All dmem_* outputs, stall_o contribution and every wb_* output = 0.
  - An outstanding cache response is ignored.
- dmem_resp_i while IDLE: ignored.

Decomposition:
- rv32i_types gains load_funct3_t (lb, lh, lw, lbu, lhu) and store_funct3_t if not present.
- The FSM state enum stays local.
- One combinational sub-module, load_align: inputs rdata, offset[1:0], funct3; output extended data.

Test Plan:
- ALU op, mem_valid_i=1, no access, alu_out=32'h1234 -> next edge wb_valid_o=1, wb_alu_out_o=32'h1234, stall_o never 1.
- lw addr 32'h100, resp 3 cycles after issue, rdata=32'hDEADBEEF -> dmem_read_o=1 / dmem_address_o=32'h100 held while BUSY; stall_o high 4 cycles; wb_load_data_o=32'hDEADBEEF; one wb_valid_o pulse.
- lb addr 32'h103, rdata=32'h80FF0000 -> wb_load_data_o=32'hFFFFFF80. lhu addr 32'h102, same data -> 32'h000080FF.
- sb addr 32'h201, wdata=32'h000000AB, mbe=4'b0010 -> dmem_address_o=32'h200, dmem_wdata_o=32'h0000AB00, dmem_mbe_o=4'b0010, dmem_write_o=1 until resp.
- Load issued, flush_i asserted in BUSY, resp arrives -> dmem_read_o clears at resp, wb_valid_o stays 0.
- rst asserted mid-BUSY -> next edge dmem_read_o=0, stall_o=0, wb_valid_o=0; a late resp causes no writeback.

Source files
------------

// File: rtl/mem_wb_ldst_pkg.sv
// rtl/mem_wb_ldst_pkg.sv - shared RV32I types for the load/store unit and MEM/WB register
//
// Purpose: control-word struct, load/store funct3 encodings, opcode constants
//          and a small address helper used by the load/store datapath.
// Ports:   none (package).
package mem_wb_ldst_pkg;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       load_regfile;
    } rv32i_control_word;

    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    // The cache is addressed by word; the byte offset travels separately.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_ldst_load_align.sv
// rtl/mem_wb_ldst_load_align.sv - combinational load data alignment and extension
//
// Purpose: shift the returned cache word down by the byte offset and
//          sign/zero-extend it according to the load funct3.
// Ports:   i_rdata  - raw cache word
//          i_offset - byte offset of the access within the word
//          i_funct3 - load funct3 (lb/lh/lw/lbu/lhu)
//          o_data   - aligned, extended load result
module load_align
    import mem_wb_ldst_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Misaligned halfwords are not trapped: bytes beyond the word read as zero.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (load_funct3_t'(i_funct3))
            lb:      o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            lbu:     o_data = {24'h0, w_shifted[7:0]};
            lh:      o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            lhu:     o_data = {16'h0, w_shifted[15:0]};
            lw:      o_data = w_shifted;
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_wb_ldst.sv
// rtl/mem_wb_ldst.sv - load/store access unit and MEM/WB pipeline register
//
// Purpose: issues data-cache requests for MEM-stage loads/stores, stalls the
//          pipe until the cache responds, aligns load data and registers
//          everything the WB stage needs.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          mem_*_i                  - MEM stage instruction, address, data, control
//          flush_i                  - kill the current MEM instruction
//          stall_o                  - freeze IF..MEM this cycle
//          dmem_*_o / dmem_*_i      - data-cache request / response
//          wb_*_o                   - registered WB stage state
module mem_wb_ldst
    import mem_wb_ldst_pkg::*;
#(
    parameter int width = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [width-1:0]  mem_addr_i,
    input  logic [width-1:0]  mem_wdata_i,
    input  logic [3:0]        mem_byte_en_i,
    input  rv32i_control_word mem_ctrl_word_i,
    input  logic [4:0]        mem_rd_i,
    input  logic [width-1:0]  mem_alu_out_i,
    input  logic [width-1:0]  mem_pc_plus4_i,
    input  logic [width-1:0]  mem_instr_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              dmem_read_o,
    output logic              dmem_write_o,
    output logic [width-1:0]  dmem_address_o,
    output logic [width-1:0]  dmem_wdata_o,
    output logic [3:0]        dmem_mbe_o,
    input  logic              dmem_resp_i,
    input  logic [width-1:0]  dmem_rdata_i,
    output logic              wb_valid_o,
    output rv32i_control_word wb_ctrl_word_o,
    output logic [4:0]        wb_rd_o,
    output logic [width-1:0]  wb_alu_out_o,
    output logic [width-1:0]  wb_load_data_o,
    output logic [width-1:0]  wb_pc_plus4_o,
    output logic [width-1:0]  wb_instr_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state;
    logic              r_dmem_read;
    logic              r_dmem_write;
    logic [width-1:0]  r_dmem_address;
    logic [width-1:0]  r_dmem_wdata;
    logic [3:0]        r_dmem_mbe;
    logic [1:0]        r_offset;
    logic [2:0]        r_funct3;
    logic              r_kill;

    logic              r_wb_valid;
    rv32i_control_word r_wb_ctrl_word;
    logic [4:0]        r_wb_rd;
    logic [width-1:0]  r_wb_alu_out;
    logic [width-1:0]  r_wb_load_data;
    logic [width-1:0]  r_wb_pc_plus4;
    logic [width-1:0]  r_wb_instr;

    logic              w_access;
    logic              w_issue;
    logic              w_resp;
    logic              w_stall;
    logic [31:0]       w_load_data;

    assign w_access = mem_valid_i & (mem_read_i | mem_write_i);
    assign w_issue  = (r_state == IDLE) & w_access & ~flush_i;
    assign w_resp   = (r_state == BUSY) & dmem_resp_i;
    assign w_stall  = (r_state == IDLE) ? w_issue : ~dmem_resp_i;

    // Offset and funct3 are taken from the issue-time registers so the
    // extraction is independent of whatever sits on the MEM inputs at resp.
    load_align u_load_align (
        .i_rdata  (dmem_rdata_i),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wdata   <= '0;
            r_dmem_mbe     <= '0;
            r_offset       <= '0;
            r_funct3       <= '0;
            r_kill         <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_ctrl_word <= '0;
            r_wb_rd        <= '0;
            r_wb_alu_out   <= '0;
            r_wb_load_data <= '0;
            r_wb_pc_plus4  <= '0;
            r_wb_instr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_dmem_address <= word_align(mem_addr_i);
                        r_dmem_wdata   <= mem_wdata_i << {mem_addr_i[1:0], 3'b000};
                        r_dmem_mbe     <= mem_byte_en_i;
                        // A combined read+write is treated as a pure store.
                        r_dmem_write   <= mem_write_i;
                        r_dmem_read    <= mem_read_i & ~mem_write_i;
                        r_offset       <= mem_addr_i[1:0];
                        r_funct3       <= mem_ctrl_word_i.funct3;
                        r_kill         <= 1'b0;
                        r_state        <= BUSY;
                    end
                end
                BUSY: begin
                    // The cache cannot be aborted; a flush only marks the
                    // result so it retires as a bubble.
                    if (flush_i) begin
                        r_kill <= 1'b1;
                    end
                    if (dmem_resp_i) begin
                        r_dmem_read  <= 1'b0;
                        r_dmem_write <= 1'b0;
                        r_kill       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_stall) begin
                r_wb_valid                  <= 1'b0;
                r_wb_ctrl_word.load_regfile <= 1'b0;
            end else begin
                r_wb_valid     <= mem_valid_i & ~flush_i & ~((r_state == BUSY) & r_kill);
                r_wb_ctrl_word <= mem_ctrl_word_i;
                r_wb_rd        <= mem_rd_i;
                r_wb_alu_out   <= mem_alu_out_i;
                r_wb_pc_plus4  <= mem_pc_plus4_i;
                r_wb_instr     <= mem_instr_i;
                r_wb_load_data <= (w_resp & r_dmem_read) ? w_load_data : '0;
            end
        end
    end

    assign stall_o        = w_stall;
    assign dmem_read_o    = r_dmem_read;
    assign dmem_write_o   = r_dmem_write;
    assign dmem_address_o = r_dmem_address;
    assign dmem_wdata_o   = r_dmem_wdata;
    assign dmem_mbe_o     = r_dmem_mbe;
    assign wb_valid_o     = r_wb_valid;
    assign wb_ctrl_word_o = r_wb_ctrl_word;
    assign wb_rd_o        = r_wb_rd;
    assign wb_alu_out_o   = r_wb_alu_out;
    assign wb_load_data_o = r_wb_load_data;
    assign wb_pc_plus4_o  = r_wb_pc_plus4;
    assign wb_instr_o     = r_wb_instr;

endmodule

// File: tb/tb_mem_wb_ldst.sv
// tb/tb_mem_wb_ldst.sv - directed self-checking bench for mem_wb_ldst
module tb_mem_wb_ldst;
    import mem_wb_ldst_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_valid_i, mem_read_i, mem_write_i;
    logic [31:0]       mem_addr_i, mem_wdata_i;
    logic [3:0]        mem_byte_en_i;
    rv32i_control_word mem_ctrl_word_i;
    logic [4:0]        mem_rd_i;
    logic [31:0]       mem_alu_out_i, mem_pc_plus4_i, mem_instr_i;
    logic              flush_i;
    logic              stall_o;
    logic              dmem_read_o, dmem_write_o;
    logic [31:0]       dmem_address_o, dmem_wdata_o;
    logic [3:0]        dmem_mbe_o;
    logic              dmem_resp_i;
    logic [31:0]       dmem_rdata_i;
    logic              wb_valid_o;
    rv32i_control_word wb_ctrl_word_o;
    logic [4:0]        wb_rd_o;
    logic [31:0]       wb_alu_out_o, wb_load_data_o, wb_pc_plus4_o, wb_instr_o;

    int n_checks = 0;
    int n_errors = 0;

    int          a_stall, a_pulse, a_hold_bad;
    logic [31:0] a_data, a_wdata;
    logic [1:0]  a_rw_after;

    always #5 clk = ~clk;

    mem_wb_ldst #(.width(32)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_byte_en_i(mem_byte_en_i),
        .mem_ctrl_word_i(mem_ctrl_word_i), .mem_rd_i(mem_rd_i), .mem_alu_out_i(mem_alu_out_i),
        .mem_pc_plus4_i(mem_pc_plus4_i), .mem_instr_i(mem_instr_i), .flush_i(flush_i),
        .stall_o(stall_o), .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_address_o(dmem_address_o), .dmem_wdata_o(dmem_wdata_o), .dmem_mbe_o(dmem_mbe_o),
        .dmem_resp_i(dmem_resp_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_ctrl_word_o(wb_ctrl_word_o), .wb_rd_o(wb_rd_o),
        .wb_alu_out_o(wb_alu_out_o), .wb_load_data_o(wb_load_data_o),
        .wb_pc_plus4_o(wb_pc_plus4_o), .wb_instr_o(wb_instr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        flush_i = 1'b0;
    endtask

    // Runs one memory access; resp is returned in BUSY cycle d (d>=1).
    // flush_k selects a BUSY cycle in which flush_i is raised (0 = none).
    task automatic do_access(input logic rd_i, input logic wr_i, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mbe,
                             input logic [2:0] f3, input int d, input logic [31:0] rdata,
                             input int flush_k);
        mem_valid_i = 1'b1; mem_read_i = rd_i; mem_write_i = wr_i;
        mem_addr_i = addr; mem_wdata_i = wdata; mem_byte_en_i = mbe;
        mem_ctrl_word_i = '{opcode: (wr_i ? op_store : op_load), funct3: f3, load_regfile: ~wr_i};
        mem_rd_i = 5'd7; mem_alu_out_i = addr; mem_pc_plus4_i = 32'h40; mem_instr_i = 32'h13;
        a_stall = 0; a_pulse = 0; a_hold_bad = 0; a_data = 32'h0; a_wdata = 32'h0;
        for (int k = 0; k <= d; k++) begin
            flush_i = (flush_k != 0) && (k == flush_k);
            #1;
            if (stall_o) a_stall++;
            @(posedge clk);
            #1;
            dmem_resp_i = 1'b0;
            if (wb_valid_o) begin
                a_pulse++;
                a_data = wb_load_data_o;
            end
            if (k < d) begin
                if (dmem_address_o !== {addr[31:2], 2'b00} || dmem_read_o !== (rd_i & ~wr_i) ||
                    dmem_write_o !== wr_i || dmem_mbe_o !== mbe)
                    a_hold_bad++;
                if (k == 0) a_wdata = dmem_wdata_o;
            end
            if (k == d - 1) begin
                dmem_resp_i = 1'b1;
                dmem_rdata_i = rdata;
            end
        end
        a_rw_after = {dmem_read_o, dmem_write_o};
        idle_inputs();
        @(posedge clk);
        #1;
        if (wb_valid_o) a_pulse++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_addr_i = 0; mem_wdata_i = 0; mem_byte_en_i = 0; mem_ctrl_word_i = '0;
        mem_rd_i = 0; mem_alu_out_i = 0; mem_pc_plus4_i = 0; mem_instr_i = 0;
        dmem_resp_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        check("rst_dmem_read", {31'h0, dmem_read_o}, 32'h0);
        check("rst_dmem_write", {31'h0, dmem_write_o}, 32'h0);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_load_data", wb_load_data_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU op passes straight through
        mem_valid_i = 1'b1; mem_alu_out_i = 32'h1234; mem_rd_i = 5'd3;
        mem_ctrl_word_i = '{opcode: op_reg, funct3: 3'b000, load_regfile: 1'b1};
        #1;
        check("alu_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk);
        #1;
        check("alu_wb_valid", {31'h0, wb_valid_o}, 32'h1);
        check("alu_wb_alu", wb_alu_out_o, 32'h1234);
        check("alu_wb_rd", {27'h0, wb_rd_o}, 32'h3);
        check("alu_load_data", wb_load_data_o, 32'h0);
        idle_inputs();
        @(posedge clk);
        #1;

        // lw, resp in 4th BUSY cycle
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'b1111, lw, 4, 32'hDEADBEEF, 0);
        check("lw_stall_cycles", a_stall, 32'd4);
        check("lw_hold", a_hold_bad, 32'd0);
        check("lw_pulses", a_pulse, 32'd1);
        check("lw_data", a_data, 32'hDEADBEEF);
        check("lw_rw_after", {30'h0, a_rw_after}, 32'h0);

        // lb at offset 3, resp in first BUSY cycle
        do_access(1'b1, 1'b0, 32'h103, 32'h0, 4'b1000, lb, 1, 32'h80FF0000, 0);
        check("lb_stall_cycles", a_stall, 32'd1);
        check("lb_pulses", a_pulse, 32'd1);
        check("lb_data", a_data, 32'hFFFFFF80);

        do_access(1'b1, 1'b0, 32'h102, 32'h0, 4'b1100, lhu, 2, 32'h80FF0000, 0);
        check("lhu_data", a_data, 32'h000080FF);

        // Misaligned lh: upper byte shifted out reads as zero
        do_access(1'b1, 1'b0, 32'h103, 32'h0, 4'b1000, lh, 2, 32'h80FF0000, 0);
        check("lh_mis_data", a_data, 32'h00000080);

        // sb at offset 1
        do_access(1'b0, 1'b1, 32'h201, 32'h000000AB, 4'b0010, sb, 2, 32'hFFFFFFFF, 0);
        check("sb_hold", a_hold_bad, 32'd0);
        check("sb_wdata", a_wdata, 32'h0000AB00);
        check("sb_pulses", a_pulse, 32'd1);
        check("sb_load_data", a_data, 32'h0);
        check("sb_rw_after", {30'h0, a_rw_after}, 32'h0);

        // read+write together: write wins, no load data
        do_access(1'b1, 1'b1, 32'h300, 32'h55667788, 4'b1111, sw, 1, 32'h12345678, 0);
        check("rw_hold", a_hold_bad, 32'd0);
        check("rw_load_data", a_data, 32'h0);

        // flush during BUSY: completes, retires as bubble
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'b1111, lw, 3, 32'hCAFEF00D, 1);
        check("flushb_stall_cycles", a_stall, 32'd3);
        check("flushb_pulses", a_pulse, 32'd0);
        check("flushb_rw_after", {30'h0, a_rw_after}, 32'h0);

        // a following load must not inherit the kill
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 4'b1111, lw, 1, 32'h0BADCAFE, 0);
        check("postflush_pulses", a_pulse, 32'd1);
        check("postflush_data", a_data, 32'h0BADCAFE);

        // flush in IDLE with access: nothing issued
        mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_addr_i = 32'h100; flush_i = 1'b1;
        mem_ctrl_word_i = '{opcode: op_load, funct3: lw, load_regfile: 1'b1};
        #1;
        check("flushi_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk);
        #1;
        check("flushi_read", {31'h0, dmem_read_o}, 32'h0);
        check("flushi_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        idle_inputs();
        @(posedge clk);
        #1;

        // reset mid-BUSY, late resp ignored
        mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_addr_i = 32'h100;
        @(posedge clk);
        #1;
        check("rstb_busy_read", {31'h0, dmem_read_o}, 32'h1);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("rstb_read", {31'h0, dmem_read_o}, 32'h0);
        check("rstb_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        check("rstb_stall", {31'h0, stall_o}, 32'h0);
        rst = 1'b0;
        dmem_resp_i = 1'b1; dmem_rdata_i = 32'h11111111;
        @(posedge clk);
        #1;
        dmem_resp_i = 1'b0;
        check("late_resp_wb_valid", {31'h0, wb_valid_o}, 32'h0);
        check("late_resp_load_data", wb_load_data_o, 32'h0);
        check("late_resp_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk);
        #1;
        check("late_resp_wb_valid2", {31'h0, wb_valid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
